// File: rtl/jam1_pipe_defs.sv
`default_nettype none
// ============================================================================
//  Module   : jam1_pipe_defs (package)
//  Brief    : Shared constants for the JAM-1 pipeline stages.
//  Revision : 1.0 - initial release
// ============================================================================
package jam1_pipe_defs;

    // Width of an opcode byte as delivered by stage 0.
    localparam int c_OPCODE_W = 8;

    // Default microcode step counter width; the last step index is 2^W-1.
    localparam int c_STEP_W = 2;

    // Opcode presented while the stage holds no real instruction.
    localparam logic [c_OPCODE_W-1:0] c_NOP_OPCODE = 8'h00;

    // Microcode ROM address is {opcode, step}.
    localparam int c_UCODE_ADDR_W = c_OPCODE_W + c_STEP_W;

endpackage : jam1_pipe_defs
`default_nettype wire

// File: rtl/ucode_step_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ucode_step_seq
//  Brief    : Microcode step sequencer for pipeline stage 1. Owns the step
//             counter, the valid bit and the retire/overflow decisions, and
//             hands load/advance strobes to the opcode registers above it.
//  Revision : 1.0 - initial release
// ============================================================================
module ucode_step_seq #(
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_busRequest,
    input  logic              i_flush,
    input  logic              i_ucodeEnd,
    output logic [STEP_W-1:0] o_step,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_load,
    output logic              o_advance,
    output logic              o_stepOverflow
);

    logic [STEP_W-1:0] r_step;
    logic              r_valid;
    logic              r_stepOverflow;
    logic              w_stepMax;
    logic              w_last;
    logic              w_load;
    logic              w_advance;
    logic              w_overflowHit;

    // Retire decision: ROM says done, counter exhausted, or nothing in flight
    // (an empty slot always accepts the next opcode).
    always_comb begin
        w_stepMax     = (r_step == {STEP_W{1'b1}});
        w_last        = i_ucodeEnd | w_stepMax | ~r_valid;
        w_load        = ~i_flush & ~i_busRequest & w_last;
        w_advance     = ~i_flush & ~i_busRequest & ~w_last;
        // A real instruction reaching the final step without the ROM marking
        // its end has more microcode than the counter can address.
        w_overflowHit = r_valid & w_stepMax & ~i_ucodeEnd;
    end

    // Step/valid/overflow state: flush beats stall, stall beats everything else.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_step         <= '0;
            r_valid        <= 1'b0;
            r_stepOverflow <= 1'b0;
        end else if (i_flush) begin
            r_step  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_step  <= '0;
            r_valid <= 1'b1;
            if (w_overflowHit) begin
                r_stepOverflow <= 1'b1;
            end
        end else if (w_advance) begin
            r_step <= r_step + STEP_W'(1);
        end
    end

    assign o_step         = r_step;
    assign o_valid        = r_valid;
    assign o_last         = w_last;
    assign o_load         = w_load;
    assign o_advance      = w_advance;
    assign o_stepOverflow = r_stepOverflow;

endmodule : ucode_step_seq
`default_nettype wire

// File: rtl/pipe_stage1.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage1
//  Brief    : JAM-1 pipeline stage 1. Latches the opcode from stage 0,
//             walks its microcode steps, drives the ROM address and holds
//             stage 0 off while a multi-step instruction is executing.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage1
    import jam1_pipe_defs::*;
#(
    parameter int                    STEP_W     = c_STEP_W,
    parameter logic [c_OPCODE_W-1:0] NOP_OPCODE = c_NOP_OPCODE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [c_OPCODE_W-1:0]        Pipe0Out,
    input  logic                         Pipe0Out0_IncPCRA0,
    input  logic                         Pipe0Out1_IncPCRA1,
    input  logic                         BusRequest,
    input  logic                         Flush,
    input  logic                         UcodeEnd,
    output logic [c_OPCODE_W-1:0]        Pipe1Opcode,
    output logic [STEP_W-1:0]            Pipe1Step,
    output logic [c_OPCODE_W+STEP_W-1:0] Pipe1UcodeAddr,
    output logic                         Pipe1Valid,
    output logic                         FetchSuppress,
    output logic                         Pipe1Out0_IncPCRA0,
    output logic                         Pipe1Out1_IncPCRA1,
    output logic                         StepOverflow
);

    logic [c_OPCODE_W-1:0] r_opcode;
    logic                  r_incPcRa0;
    logic                  r_incPcRa1;
    logic [STEP_W-1:0]     w_step;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_stepOverflow;

    ucode_step_seq #(
        .STEP_W (STEP_W)
    ) u_stepSeq (
        .clk            (clk),
        .i_rst          (reset),
        .i_busRequest   (BusRequest),
        .i_flush        (Flush),
        .i_ucodeEnd     (UcodeEnd),
        .o_step         (w_step),
        .o_valid        (w_valid),
        .o_last         (w_last),
        .o_load         (w_load),
        .o_advance      (w_advance),
        .o_stepOverflow (w_stepOverflow)
    );

    // Opcode and increment flags: cleared on flush, captured on load, and
    // kept unchanged while the sequencer steps or the bus is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode   <= NOP_OPCODE;
            r_incPcRa0 <= 1'b0;
            r_incPcRa1 <= 1'b0;
        end else if (Flush) begin
            r_opcode   <= NOP_OPCODE;
            r_incPcRa0 <= 1'b0;
            r_incPcRa1 <= 1'b0;
        end else if (w_load) begin
            r_opcode   <= Pipe0Out;
            r_incPcRa0 <= Pipe0Out0_IncPCRA0;
            r_incPcRa1 <= Pipe0Out1_IncPCRA1;
        end else if (w_advance) begin
            // Next microcode step of the same instruction.
            r_opcode   <= r_opcode;
            r_incPcRa0 <= r_incPcRa0;
            r_incPcRa1 <= r_incPcRa1;
        end
    end

    // Stage 0 holds on BusRequest by itself, so only an unfinished
    // instruction (and no flush) needs to suppress fetch.
    always_comb begin
        FetchSuppress = w_valid & ~w_last & ~Flush;
        Pipe1Valid    = w_valid & ~BusRequest;
    end

    assign Pipe1Opcode        = r_opcode;
    assign Pipe1Step          = w_step;
    assign Pipe1UcodeAddr     = {r_opcode, w_step};
    assign Pipe1Out0_IncPCRA0 = r_incPcRa0;
    assign Pipe1Out1_IncPCRA1 = r_incPcRa1;
    assign StepOverflow       = w_stepOverflow;

endmodule : pipe_stage1
`default_nettype wire

// File: tb/tb_pipe_stage1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage1
//  Brief    : Directed self-checking bench for pipe_stage1. Each cycle the
//             expected output image is queued alongside the stimulus and
//             popped for comparison once the outputs have settled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage1;

    typedef struct packed {
        logic [7:0] opcode;
        logic [1:0] step;
        logic [9:0] addr;
        logic       valid;
        logic       fetchSuppress;
        logic       inc0;
        logic       inc1;
        logic       overflow;
    } outImage_t;

    logic       clk;
    logic       reset;
    logic [7:0] Pipe0Out;
    logic       Pipe0Out0_IncPCRA0;
    logic       Pipe0Out1_IncPCRA1;
    logic       BusRequest;
    logic       Flush;
    logic       UcodeEnd;
    logic [7:0] Pipe1Opcode;
    logic [1:0] Pipe1Step;
    logic [9:0] Pipe1UcodeAddr;
    logic       Pipe1Valid;
    logic       FetchSuppress;
    logic       Pipe1Out0_IncPCRA0;
    logic       Pipe1Out1_IncPCRA1;
    logic       StepOverflow;

    outImage_t  expQ[$];
    int         errCnt = 0;
    int         chkCnt = 0;

    pipe_stage1 #(
        .STEP_W     (2),
        .NOP_OPCODE (8'h00)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .Pipe0Out           (Pipe0Out),
        .Pipe0Out0_IncPCRA0 (Pipe0Out0_IncPCRA0),
        .Pipe0Out1_IncPCRA1 (Pipe0Out1_IncPCRA1),
        .BusRequest         (BusRequest),
        .Flush              (Flush),
        .UcodeEnd           (UcodeEnd),
        .Pipe1Opcode        (Pipe1Opcode),
        .Pipe1Step          (Pipe1Step),
        .Pipe1UcodeAddr     (Pipe1UcodeAddr),
        .Pipe1Valid         (Pipe1Valid),
        .FetchSuppress      (FetchSuppress),
        .Pipe1Out0_IncPCRA0 (Pipe1Out0_IncPCRA0),
        .Pipe1Out1_IncPCRA1 (Pipe1Out1_IncPCRA1),
        .StepOverflow       (StepOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive this cycle's inputs.
    task automatic setIn(input logic [7:0] p0, input logic i0, input logic i1,
                         input logic ue, input logic br, input logic fl);
        Pipe0Out           = p0;
        Pipe0Out0_IncPCRA0 = i0;
        Pipe0Out1_IncPCRA1 = i1;
        UcodeEnd           = ue;
        BusRequest         = br;
        Flush              = fl;
    endtask

    // Queue the output image the current cycle must show.
    task automatic expectOut(input logic [7:0] op, input logic [1:0] st,
                             input logic vld, input logic fs,
                             input logic i0, input logic i1, input logic ovf);
        outImage_t e;
        e.opcode        = op;
        e.step          = st;
        e.addr          = {op, st};
        e.valid         = vld;
        e.fetchSuppress = fs;
        e.inc0          = i0;
        e.inc1          = i1;
        e.overflow      = ovf;
        expQ.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the settled outputs.
    task automatic checkOut(input string tag);
        outImage_t obs;
        outImage_t exp;
        #1;
        obs = {Pipe1Opcode, Pipe1Step, Pipe1UcodeAddr, Pipe1Valid,
               FetchSuppress, Pipe1Out0_IncPCRA0, Pipe1Out1_IncPCRA1,
               StepOverflow};
        chkCnt++;
        if (expQ.size() == 0) begin
            errCnt++;
            $display("FAIL %s: observed=%h required=<queued expectation>", tag, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                errCnt++;
                $error("FAIL %s: observed op=%h st=%0d addr=%h v=%b fs=%b inc=%b%b ovf=%b required op=%h st=%0d addr=%h v=%b fs=%b inc=%b%b ovf=%b",
                       tag, obs.opcode, obs.step, obs.addr, obs.valid, obs.fetchSuppress,
                       obs.inc0, obs.inc1, obs.overflow,
                       exp.opcode, exp.step, exp.addr, exp.valid, exp.fetchSuppress,
                       exp.inc0, exp.inc1, exp.overflow);
            end
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        setIn(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        #7 reset = 1'b1;
        expectOut(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("reset_async");
        #9 reset = 1'b0;   // released mid-cycle after the 15ns edge
        expectOut(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("reset_release");

        // First edge after reset loads 5A: address 10'h168.
        tick(); setIn(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expectOut(8'h5A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); checkOut("load_5A");

        // Single-step stream.
        tick(); setIn(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expectOut(8'h11, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); checkOut("stream_11");
        tick(); setIn(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectOut(8'h22, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); checkOut("stream_22");
        tick(); setIn(8'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expectOut(8'h33, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("stream_33");

        // Three-step instruction 40.
        tick(); setIn(8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectOut(8'h40, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); checkOut("multi_s0");
        tick();
        expectOut(8'h40, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); checkOut("multi_s1");
        tick(); setIn(8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectOut(8'h40, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); checkOut("multi_s2");
        tick(); setIn(8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expectOut(8'h41, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("multi_next");

        // Bus stall for three cycles at step 1.
        tick(); setIn(8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expectOut(8'h40, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOut("stall_s0");
        for (int i = 0; i < 3; i++) begin
            tick(); setIn(8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            expectOut(8'h40, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); checkOut("stall_hold");
        end
        tick(); setIn(8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expectOut(8'h40, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOut("stall_resume_s1");
        tick(); setIn(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expectOut(8'h40, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); checkOut("stall_resume_s2");

        // Flush together with BusRequest at step 1 of 77.
        tick(); setIn(8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expectOut(8'h77, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); checkOut("flush_pre_s0");
        tick(); setIn(8'h88, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expectOut(8'h77, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); checkOut("flush_cycle");
        tick(); setIn(8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expectOut(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("flush_bubble");

        // UcodeEnd never asserted: forced retire at step 3 raises overflow.
        tick(); setIn(8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expectOut(8'h88, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOut("ovf_s0");
        tick();
        expectOut(8'h88, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOut("ovf_s1");
        tick();
        expectOut(8'h88, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOut("ovf_s2");
        tick();
        expectOut(8'h88, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); checkOut("ovf_s3_max");
        tick(); setIn(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectOut(8'h99, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); checkOut("ovf_set");
        tick(); setIn(8'hBB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expectOut(8'hAA, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); checkOut("ovf_sticky");
        tick(); setIn(8'hBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expectOut(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checkOut("ovf_after_flush");

        // Reset in the middle of a multi-step instruction.
        tick();
        expectOut(8'hBB, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); checkOut("midrst_s0");
        tick();
        expectOut(8'hBB, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); checkOut("midrst_s1");
        #2 reset = 1'b1;
        expectOut(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("midrst_cleared");
        tick(); reset = 1'b0;
        expectOut(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOut("midrst_release");

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule : tb_pipe_stage1
`default_nettype wire

// File: doc/pipe_stage1.md
Name: pipe_stage1

Overview:
- Pipeline stage 1 of the JAM-1 CPU. Sits directly downstream of pipe_stage0 and consumes its opcode byte (Pipe0Out) and PC/RA increment flags.
- Latches each instruction and sequences its microcode steps. Drives the microcode ROM address {opcode, step}.
- Asserts FetchSuppress back to stage 0 while a multi-step instruction is still executing. Handles bus stalls and branch flushes.

Parameters:
- STEP_W, 2, width of the microcode step counter; the maximum step is 2^STEP_W-1.
- NOP_OPCODE, 8'h00, opcode injected on reset and on flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Pipe0Out  in  8  opcode byte from stage 0.
- Pipe0Out0_IncPCRA0  in  1  stage 0 increment flag 0.
- Pipe0Out1_IncPCRA1  in  1  stage 0 increment flag 1.
- BusRequest  in  1  external bus master request; stalls this stage.
- Flush  in  1  branch taken / pipeline flush from a later stage.
- UcodeEnd  in  1  microcode ROM bit: the current {opcode, step} is the last step.
- Pipe1Opcode  out  8  latched opcode.
- Pipe1Step  out  STEP_W  current microcode step.
- Pipe1UcodeAddr  out  8+STEP_W  {Pipe1Opcode, Pipe1Step}.
- Pipe1Valid  out  1  the current opcode/step is a real instruction.
- FetchSuppress  out  1  to stage 0: hold fetch this cycle.
- Pipe1Out0_IncPCRA0  out  1  registered copy of the increment flag 0.
- Pipe1Out1_IncPCRA1  out  1  registered copy of the increment flag 1.
- StepOverflow  out  1  sticky error flag: an instruction ran out of steps.

Behaviour:
- Reset (async, immediate) sets the following values:
  - opcode = NOP_OPCODE, step = 0, valid = 0.
  - Both IncPCRA outputs = 0, StepOverflow = 0.
  - FetchSuppress = 0.
- Pipe1UcodeAddr is combinational from the opcode/step registers. The ROM returns UcodeEnd in the same cycle.
- "Last" condition: last = UcodeEnd OR (step == 2^STEP_W-1) OR (valid == 0).
- FetchSuppress (combinational) = valid AND NOT last AND NOT Flush. A bus stall does not suppress fetch, because stage 0 holds on BusRequest itself.
- Pipe1Valid = valid AND NOT BusRequest. A stalled cycle presents no valid operation.
- Edge priority, highest first:
  1. Flush = 1 → opcode = NOP_OPCODE, step = 0, valid = 0, IncPCRA outputs = 0. Flush overrides BusRequest.
  2. BusRequest = 1 → all registers hold.
  3. last = 1 → load the next instruction:
     - opcode = Pipe0Out, step = 0, valid = 1.
     - IncPCRA outputs take Pipe0Out*_IncPCRA*.
     - If step == max and UcodeEnd == 0 while valid, set StepOverflow (sticky until reset).
  4. Otherwise → step = step+1; opcode and IncPCRA outputs hold.
- Single-step instruction: one cycle per opcode, zero bubbles, FetchSuppress never asserted.
- N-step instruction (N ≤ 2^STEP_W): the opcode is held for N cycles and FetchSuppress is high for the first N-1 of them.
- The step counter never wraps. At the maximum step the instruction is force-retired.
- After a flush, one cycle has valid = 0. On the next edge, Pipe0Out is loaded as a new instruction because valid = 0 makes last = 1.
- Reset mid-instruction abandons the step sequence with no residual suppress.

Decomposition:
- Shared package/header `jam1_pipe_defs`:
  - NOP_OPCODE.
  - STEP_W.
  - Microcode address width localparam.
- One natural sub-module, `ucode_step_seq`, owns the following:
  - the step counter;
  - the valid bit;
  - the last/overflow logic.
  It exports the load and advance strobes.
- The top level holds the opcode and IncPCRA registers.

Test Plan:
- Reset asserted mid-cycle, Pipe0Out = 8'h5A → outputs immediately show opcode 00, step 0, Pipe1Valid 0, FetchSuppress 0. After release with UcodeEnd = 1: next edge gives opcode 5A, Pipe1UcodeAddr = 10'h168.
- Stream 8'h11, 8'h22, 8'h33 with UcodeEnd = 1 → one opcode per cycle, step always 0, FetchSuppress never high.
- Opcode 8'h40 with UcodeEnd = 0, 0, 1 on steps 0, 1, 2 → steps 0, 1, 2 with FetchSuppress = 1, 1, 0. The next opcode loads on the 4th edge.
- Opcode 8'h40 at step 1, BusRequest held 3 cycles → step stays 1 and Pipe1Valid = 0 throughout. Afterwards the sequence continues at step 2.
- Flush and BusRequest together at step 1 of a multi-step op → next cycle opcode 00, valid 0, IncPCRA outputs 0. The following edge loads Pipe0Out.
- UcodeEnd held 0 for an opcode → steps 0–3, then force-load of the next opcode and StepOverflow = 1, which stays set until reset.
